// File: rtl/data_mem_if.sv
// CPU data-memory bus: the cpu drives requests and the responder returns data and status.
interface data_mem_if;
    logic [31:0] data_address;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_out;
    logic        mem_ready;
    logic        mem_err;

    modport master (
        output data_address, data_in, mem_read, mem_write,
        input  data_out, mem_ready, mem_err
    );

    modport slave (
        input  data_address, data_in, mem_read, mem_write,
        output data_out, mem_ready, mem_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: captures a request, waits LATENCY edges, then
// completes it against a word-addressed RAM with a one-cycle mem_ready pulse.
module data_mem_responder #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 2
) (
    input logic       clk,
    input logic       rst,
    data_mem_if.slave bus
);

    localparam int unsigned Depth   = 2 ** ADDR_BITS;
    localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] dout_q;
    logic        ready_q;
    logic        err_q;
    logic [31:0] ram_q [Depth];

    logic [ADDR_BITS-1:0] index;
    logic                 req_err;
    logic                 exec;
    logic                 ram_we;

    // All decode works on the captured request so bus changes after acceptance are ignored.
    always_comb begin
        index   = addr_q[ADDR_BITS+1:2];
        req_err = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_BITS+2] != '0) || (rd_q && wr_q);
        exec    = (state_q == StWait) && (cnt_q == 4'd0);
        ram_we  = rst && exec && wr_q && !req_err;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.mem_read || bus.mem_write) begin
                        addr_q  <= bus.data_address;
                        wdata_q <= bus.data_in;
                        rd_q    <= bus.mem_read;
                        wr_q    <= bus.mem_write;
                        cnt_q   <= CntInit;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        ready_q <= 1'b1;
                        err_q   <= req_err;
                        if (req_err) begin
                            dout_q <= '0;
                        end else if (rd_q) begin
                            dout_q <= ram_q[index];
                        end
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // RAM has no reset; the write enable is gated by rst so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[index] <= wdata_q;
        end
    end

    assign bus.data_out  = dout_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_err   = err_q;

endmodule
